// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL / DIVU / REMU sequencer: one shift-add or restoring-divide step per cycle.
// Optional feature: define MULDIV_EARLY_OUT_EN to let MUL finish once the remaining multiplier is zero.
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_acc;     // MUL accumulator / divide partial remainder
    logic [XLEN-1:0] r_a;       // MUL multiplicand / divide dividend-quotient shift register
    logic [XLEN-1:0] r_b;       // MUL multiplier / divisor
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_result_valid;
    logic            r_start_ready;
    logic            r_busy;

    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN-1:0] w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_div_rem;
    logic [XLEN-1:0] w_div_quo;
    logic            w_last;
    logic            w_mul_end;
    logic            w_mul_zero;

    assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

    // The bit shifted out of the remainder makes it exceed any XLEN-bit divisor, so it forces a subtract;
    // the low XLEN bits of the difference are then still exact.
    assign w_rem_sh  = {r_acc[XLEN-2:0], r_a[XLEN-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {1'b0, r_b};
    assign w_qbit    = r_acc[XLEN-1] | ~w_diff[XLEN];
    assign w_div_rem = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh;
    assign w_div_quo = {r_a[XLEN-2:0], w_qbit};

    assign w_last = (r_cnt == CW'(XLEN-1));

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_end  = w_last | ((r_b >> 1) == '0);
    assign w_mul_zero = (in2 == '0);
`else
    assign w_mul_end  = w_last;
    assign w_mul_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_op           <= '0;
            r_acc          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
        end else if (flush) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_op          <= op;
                        r_acc         <= '0;
                        r_a           <= in1;
                        r_b           <= in2;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (op == 2'b11) begin
                            r_state        <= DONE;
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                        end else if (op != OP_MUL && in2 == '0) begin
                            r_state        <= DONE;
                            r_result       <= (op == OP_DIVU) ? '1 : in1;
                            r_result_valid <= 1'b1;
                        end else if (op == OP_MUL && w_mul_zero) begin
                            r_state        <= DONE;
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        if (w_mul_end) begin
                            r_state        <= DONE;
                            r_result       <= w_mul_acc;
                            r_result_valid <= 1'b1;
                        end
                    end else begin
                        r_acc <= w_div_rem;
                        r_a   <= w_div_quo;
                        if (w_last) begin
                            r_state        <= DONE;
                            r_result       <= (r_op == OP_REMU) ? w_div_rem : w_div_quo;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign busy         = r_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random MUL/DIVU/REMU against a plain-arithmetic reference,
// plus latency, backpressure, flush and asynchronous reset behaviour.
module tb_muldiv_seq;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] in1 = '0;
    logic [XLEN-1:0] in2 = '0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .in1          (in1),
        .in2          (in2),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Architectural result of each operation, straight from the RV64M definitions.
    function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (o)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? {XLEN{1'b1}} : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [XLEN-1:0] b);
        if (o == 2'b11) return 0;
        if (o != 2'b00 && b == 0) return 0;
        return XLEN;
    endfunction

    // Issue one request and check latency (edges after the accept edge), result and handshake.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input string tag, input int hold);
        int edges;
        logic [XLEN-1:0] held;
        op = o; in1 = a; in2 = b; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op = 2'($urandom); in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
        edges = 0;
        while (result_valid !== 1'b1 && edges < XLEN + 8) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_lat"}, XLEN'(edges), XLEN'(model_lat(o, b)));
        chk({tag, "_res"}, result, model(o, a, b));
        chk({tag, "_busy"}, XLEN'(busy), XLEN'(1));
        chk({tag, "_sready_lo"}, XLEN'(start_ready), XLEN'(0));
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_res"}, result, held);
            chk({tag, "_hold_vld"}, XLEN'(result_valid), XLEN'(1));
            chk({tag, "_hold_sready"}, XLEN'(start_ready), XLEN'(0));
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, "_idle_sready"}, XLEN'(start_ready), XLEN'(1));
        chk({tag, "_idle_busy"}, XLEN'(busy), XLEN'(0));
        chk({tag, "_idle_vld"}, XLEN'(result_valid), XLEN'(0));
    endtask

    initial begin
        logic [1:0]      ro;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        int              sel;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, '0);
        chk("rst_vld", XLEN'(result_valid), XLEN'(0));
        chk("rst_sready", XLEN'(start_ready), XLEN'(1));
        chk("rst_busy", XLEN'(busy), XLEN'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 64'd7, 64'd9, "mul_7x9", 0);
        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mul_wrap", 0);
        run_op(2'b01, 64'd100, 64'd7, "divu_100_7", 0);
        run_op(2'b10, 64'd100, 64'd7, "remu_100_7", 0);
        run_op(2'b01, 64'd5, 64'd0, "divu_by0", 0);
        run_op(2'b10, 64'd5, 64'd0, "remu_by0", 0);
        run_op(2'b11, 64'd123, 64'd45, "op_rsvd", 0);
        run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, "divu_bigdiv", 0);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, "remu_bigdiv", 0);
        run_op(2'b01, 64'd100, 64'd7, "backpressure", 10);

        for (int i = 0; i < 14; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            sel = $urandom_range(0, 4);
            case (sel)
                0:       rb = {$urandom, $urandom};
                1:       rb = XLEN'($urandom_range(1, 1000));
                2:       rb = '0;
                3:       rb = {1'b1, 31'($urandom), 32'($urandom)};
                default: rb = XLEN'($urandom);
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", i), 0);
        end

        // Flush at step 30 of a DIVU, with a new request presented on the same edge.
        op = 2'b01; in1 = 64'd1000; in2 = 64'd3; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("flush_pre_busy", XLEN'(busy), XLEN'(1));
        flush = 1'b1; start_valid = 1'b1; op = 2'b11; in1 = 64'd9; in2 = 64'd9;
        @(posedge clk); #1;
        flush = 1'b0; start_valid = 1'b0;
        chk("flush_sready", XLEN'(start_ready), XLEN'(1));
        chk("flush_busy", XLEN'(busy), XLEN'(0));
        chk("flush_vld", XLEN'(result_valid), XLEN'(0));
        repeat (XLEN + 4) @(posedge clk);
        #1;
        chk("flush_no_accept_busy", XLEN'(busy), XLEN'(0));
        chk("flush_no_accept_vld", XLEN'(result_valid), XLEN'(0));

        // Asynchronous reset in the middle of a MUL.
        op = 2'b00; in1 = 64'd11; in2 = 64'd13; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sready", XLEN'(start_ready), XLEN'(1));
        chk("arst_busy", XLEN'(busy), XLEN'(0));
        chk("arst_vld", XLEN'(result_valid), XLEN'(0));
        chk("arst_result", result, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (XLEN + 4) @(posedge clk);
        #1;
        chk("arst_no_result", XLEN'(result_valid), XLEN'(0));

        run_op(2'b10, 64'd100, 64'd7, "post_reset_remu", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
